// File: rtl/sy_pkg.sv
// Constants for the register-to-TileLink bridge: transfer size code and
// the byte masks selecting the low / high 32-bit lane of the 64-bit bus.
package sy_pkg;

  localparam logic [2:0] REG2TL_SIZE_WORD = 3'd2;   // log2(4 bytes)
  localparam logic [7:0] REG2TL_MASK_LO   = 8'h0F;
  localparam logic [7:0] REG2TL_MASK_HI   = 8'hF0;

endpackage

// File: rtl/tl_pkg.sv
// TileLink-UL channel definitions shared by the fabric.
// A channel carries Get / PutFullData requests, D channel carries
// AccessAck / AccessAckData responses. Data bus is 64 bits wide.
package tl_pkg;

  typedef logic [7:0] source_t;

  // A channel opcodes
  localparam logic [2:0] PUT_FULL_DATA   = 3'd0;
  localparam logic [2:0] GET             = 3'd4;
  // D channel opcodes
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [2:0]  size;
    source_t     source;
    logic [63:0] address;
    logic [7:0]  mask;
    logic [63:0] data;
    logic        corrupt;
  } A_chan_bits_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [2:0]  size;
    source_t     source;
    logic        sink;
    logic        denied;
    logic [63:0] data;
    logic        corrupt;
  } D_chan_bits_t;

endpackage

// File: rtl/reg2tl_bridge.sv
// Register-bus slave to TileLink-UL client bridge.
// Each 32-bit register access becomes one Get / PutFullData on the 64-bit
// A channel; the D response is turned into a one-cycle rvalid_o pulse with
// read data and error. Exactly one access is in flight at a time.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   req_i/gnt_o            register request handshake (gnt_o only in IDLE)
//   we_i, addr_i, wdata_i  request payload
//   rvalid_o, rdata_o,     response pulse, read data, error flag
//   err_o
//   TL_A_*                 TileLink A channel (request out)
//   TL_D_*                 TileLink D channel (response in)
//
// Optional: define REG2TL_TIMEOUT_EN to bound the WAIT_D phase to
// TIMEOUT_CYCLES cycles. A timed-out access answers with an error and the
// late D beat is then swallowed before the next request is granted.
module reg2tl_bridge
  import tl_pkg::*;
  import sy_pkg::*;
#(
  parameter int      ADDR_WIDTH     = 64,
  parameter source_t SOURCE_ID      = '0,
  parameter int      TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  output logic                  TL_A_valid_o,
  input  logic                  TL_A_ready_i,
  output A_chan_bits_t          TL_A_bits_o,
  input  logic                  TL_D_valid_i,
  output logic                  TL_D_ready_o,
  input  D_chan_bits_t          TL_D_bits_i
);

  typedef enum logic [1:0] {IDLE, SEND_A, WAIT_D, RESP} state_e;

  state_e                state_q, state_d;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  d_err;
  logic [31:0]           d_lane;
  logic                  timeout;

`ifdef REG2TL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             stale_q;   // a timed-out access still owes us a D beat

  assign timeout = (state_q == WAIT_D) && !TL_D_valid_i &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      stale_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == WAIT_D && state_d == WAIT_D) ? cnt_q + 1'b1 : '0;
      if (timeout)
        stale_q <= 1'b1;
      else if (state_q == IDLE && TL_D_valid_i)
        stale_q <= 1'b0;   // the late beat is accepted and dropped here
    end
  end

  assign gnt_o        = (state_q == IDLE) && req_i && !stale_q;
  assign TL_D_ready_o = (state_q == WAIT_D) || (state_q == IDLE && stale_q);
`else
  assign timeout      = 1'b0;
  assign gnt_o        = (state_q == IDLE) && req_i;
  assign TL_D_ready_o = (state_q == WAIT_D);
`endif

  assign TL_A_valid_o = (state_q == SEND_A);
  assign rvalid_o     = (state_q == RESP);
  assign rdata_o      = rdata_q;
  assign err_o        = err_q;

  // A payload comes only from captured registers, so it is stable while
  // the fabric stalls us.
  always_comb begin
    TL_A_bits_o         = '0;
    TL_A_bits_o.opcode  = we_q ? PUT_FULL_DATA : GET;
    TL_A_bits_o.param   = 3'd0;
    TL_A_bits_o.size    = REG2TL_SIZE_WORD;
    TL_A_bits_o.source  = SOURCE_ID;
    TL_A_bits_o.address = 64'({addr_q[ADDR_WIDTH-1:2], 2'b00});
    TL_A_bits_o.mask    = addr_q[2] ? REG2TL_MASK_HI : REG2TL_MASK_LO;
    TL_A_bits_o.data    = {wdata_q, wdata_q};
    TL_A_bits_o.corrupt = 1'b0;
  end

  assign d_lane = addr_q[2] ? TL_D_bits_i.data[63:32] : TL_D_bits_i.data[31:0];
  assign d_err  = TL_D_bits_i.denied || TL_D_bits_i.corrupt ||
                  (TL_D_bits_i.source != SOURCE_ID) ||
                  (TL_D_bits_i.opcode != (we_q ? ACCESS_ACK : ACCESS_ACK_DATA));

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_o) begin
          if (addr_i[1:0] != 2'b00) begin
            // misaligned: answer locally, never touch the fabric
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = SEND_A;
          end
        end
      end
      SEND_A: if (TL_A_ready_i) state_d = WAIT_D;
      WAIT_D: begin
        if (TL_D_valid_i) begin
          state_d = RESP;
          err_d   = d_err;
          rdata_d = (we_q || d_err) ? 32'h0 : d_lane;
        end else if (timeout) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (gnt_o) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
    end
  end

  // D fields the bridge has no use for, and the byte offset which is
  // already folded into the alignment check.
  logic unused_bits;
  assign unused_bits = ^{addr_q[1:0], TL_D_bits_i.param, TL_D_bits_i.size,
                         TL_D_bits_i.sink};

endmodule

// File: tb/tb_reg2tl_bridge.sv
module tb_reg2tl_bridge;
  import tl_pkg::*;

  localparam int TO = 8;
`ifdef REG2TL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         req_i = 1'b0;
  logic         gnt_o;
  logic         we_i = 1'b0;
  logic [63:0]  addr_i = '0;
  logic [31:0]  wdata_i = '0;
  logic         rvalid_o;
  logic [31:0]  rdata_o;
  logic         err_o;
  logic         TL_A_valid_o;
  logic         TL_A_ready_i = 1'b0;
  A_chan_bits_t TL_A_bits_o;
  logic         TL_D_valid_i = 1'b0;
  logic         TL_D_ready_o;
  D_chan_bits_t TL_D_bits_i = '0;

  reg2tl_bridge #(.ADDR_WIDTH(64), .SOURCE_ID(8'h00), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .TL_A_valid_o(TL_A_valid_o), .TL_A_ready_i(TL_A_ready_i),
    .TL_A_bits_o(TL_A_bits_o), .TL_D_valid_i(TL_D_valid_i),
    .TL_D_ready_o(TL_D_ready_o), .TL_D_bits_i(TL_D_bits_i));

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model + compare process ----------------
  logic         busy = 1'b0, a_pend = 1'b0, waiting = 1'b0, stale = 1'b0;
  logic         prev_stall = 1'b0;
  A_chan_bits_t prev_a, exp_a, last_a;
  logic         cur_we;
  logic [63:0]  cur_addr;
  int           wcnt = 0;
  logic [31:0]  exp_rd_q[$];
  logic         exp_err_q[$];
  int           g_cyc = 0, r_cyc = 0, fire_cnt = 0, rv_cnt = 0;
  logic [31:0]  last_rdata;
  logic         last_err;

  always @(negedge clk_i) begin
    if (rst_i) begin
      exp_rd_q.delete(); exp_err_q.delete();
      busy = 0; a_pend = 0; waiting = 0; stale = 0; prev_stall = 0;
    end else begin
      chk("gnt", 256'(gnt_o), 256'(req_i && !busy && !stale));
      chk("a_valid", 256'(TL_A_valid_o), 256'(a_pend));
      chk("d_ready", 256'(TL_D_ready_o), 256'(waiting || (stale && !busy)));
      if (prev_stall && TL_A_valid_o) chk("a_stable", 256'(TL_A_bits_o), 256'(prev_a));
      prev_stall = TL_A_valid_o && !TL_A_ready_i;
      prev_a     = TL_A_bits_o;

      if (rvalid_o) begin
        rv_cnt++;
        if (exp_rd_q.size() == 0) chk("spurious_rvalid", 256'(rvalid_o), 256'(0));
        else begin
          chk("rdata", 256'(rdata_o), 256'(exp_rd_q.pop_front()));
          chk("err", 256'(err_o), 256'(exp_err_q.pop_front()));
        end
        r_cyc = cyc; last_rdata = rdata_o; last_err = err_o; busy = 0;
      end

      if (waiting) begin
        if (TL_D_valid_i) begin
          logic e;
          e = TL_D_bits_i.denied || TL_D_bits_i.corrupt || (TL_D_bits_i.source != 8'h00) ||
              (TL_D_bits_i.opcode != (cur_we ? ACCESS_ACK : ACCESS_ACK_DATA));
          exp_err_q.push_back(e);
          exp_rd_q.push_back((e || cur_we) ? 32'h0 :
                             (cur_addr[2] ? TL_D_bits_i.data[63:32] : TL_D_bits_i.data[31:0]));
          waiting = 0;
        end else begin
          wcnt++;
          if (TO_EN && wcnt == TO) begin
            exp_err_q.push_back(1'b1); exp_rd_q.push_back(32'h0);
            stale = 1; waiting = 0;
          end
        end
      end else if (!busy && stale && TL_D_valid_i) begin
        stale = 0;
      end

      if (TL_A_valid_o && TL_A_ready_i) begin
        fire_cnt++; last_a = TL_A_bits_o;
        if (a_pend) begin
          chk("a_bits", 256'(TL_A_bits_o), 256'(exp_a));
          a_pend = 0; waiting = 1; wcnt = 0;
        end
      end

      if (req_i && gnt_o) begin
        busy = 1; cur_we = we_i; cur_addr = addr_i; g_cyc = cyc;
        if (addr_i[1:0] != 2'b00) begin
          exp_err_q.push_back(1'b1); exp_rd_q.push_back(32'h0);
        end else begin
          a_pend = 1;
          exp_a = '0;
          exp_a.opcode  = we_i ? 3'd0 : 3'd4;
          exp_a.size    = 3'd2;
          exp_a.address = {addr_i[63:2], 2'b00};
          exp_a.mask    = addr_i[2] ? 8'hF0 : 8'h0F;
          exp_a.data    = {wdata_i, wdata_i};
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // dly < 0 means the slave never answers.
  task automatic access(input logic we, input logic [63:0] a, input logic [31:0] wd,
                        input int stall, input int dly, input D_chan_bits_t d);
    int n;
    @(posedge clk_i); #1;
    req_i = 1; we_i = we; addr_i = a; wdata_i = wd; TL_A_ready_i = (stall == 0);
    n = 0;
    @(negedge clk_i);
    while (!gnt_o && n < 50) begin @(negedge clk_i); n++; end
    if (n >= 50) chk("gnt_wait", 256'(gnt_o), 256'(1));
    @(posedge clk_i); #1;
    // with a stall, keep a competing request up to show it is held off
    if (stall == 0) req_i = 0;
    if (a[1:0] == 2'b00) begin
      repeat (stall) @(posedge clk_i);
      if (stall > 0) begin #1; TL_A_ready_i = 1; req_i = 0; end
      n = 0;
      @(negedge clk_i);
      while (!(TL_A_valid_o && TL_A_ready_i) && n < 30) begin @(negedge clk_i); n++; end
      if (n >= 30) chk("a_fire_wait", 256'(TL_A_valid_o), 256'(1));
      @(posedge clk_i); #1; TL_A_ready_i = 0;
      if (dly >= 0) begin
        repeat (dly) begin @(posedge clk_i); #1; end
        TL_D_valid_i = 1; TL_D_bits_i = d;
        n = 0;
        @(negedge clk_i);
        while (!TL_D_ready_o && n < 30) begin @(negedge clk_i); n++; end
        if (n >= 30) chk("d_accept_wait", 256'(TL_D_ready_o), 256'(1));
        @(posedge clk_i); #1; TL_D_valid_i = 0;
      end
    end
    n = 0;
    @(negedge clk_i);
    while (!rvalid_o && n < 40) begin @(negedge clk_i); n++; end
    if (n >= 40) chk("rvalid_wait", 256'(rvalid_o), 256'(1));
    #1;
  endtask

  function automatic D_chan_bits_t mk_d(input logic [2:0] op, input logic [63:0] data,
                                        input logic denied);
    D_chan_bits_t d;
    d = '0; d.opcode = op; d.data = data; d.denied = denied; d.size = 3'd2;
    return d;
  endfunction

  initial begin
    D_chan_bits_t d;
    int f0, r0;
    // reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_gnt", 256'(gnt_o), 256'(0));
    chk("rst_rvalid", 256'(rvalid_o), 256'(0));
    chk("rst_err", 256'(err_o), 256'(0));
    chk("rst_rdata", 256'(rdata_o), 256'(0));
    chk("rst_a_valid", 256'(TL_A_valid_o), 256'(0));
    chk("rst_d_ready", 256'(TL_D_ready_o), 256'(0));
    @(posedge clk_i); #1; rst_i = 0;

    // write 0x12345678 @ 0x1000_0004
    access(1'b1, 64'h1000_0004, 32'h1234_5678, 0, 0, mk_d(ACCESS_ACK, 64'h0, 1'b0));
    chk("wr_opcode", 256'(last_a.opcode), 256'(0));
    chk("wr_addr", 256'(last_a.address), 256'(64'h1000_0004));
    chk("wr_mask", 256'(last_a.mask), 256'(8'hF0));
    chk("wr_data", 256'(last_a.data), 256'(64'h1234_5678_1234_5678));
    chk("wr_latency", 256'(r_cyc - g_cyc), 256'(3));
    chk("wr_err", 256'(last_err), 256'(0));

    // read low lane
    access(1'b0, 64'h1000_0000, 32'h0, 0, 0, mk_d(ACCESS_ACK_DATA, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0));
    chk("rd_lo_opcode", 256'(last_a.opcode), 256'(4));
    chk("rd_lo_mask", 256'(last_a.mask), 256'(8'h0F));
    chk("rd_lo_rdata", 256'(last_rdata), 256'(32'hCCCC_DDDD));
    chk("rd_lo_err", 256'(last_err), 256'(0));

    // read high lane with A stalled 5 cycles
    access(1'b0, 64'h1000_0004, 32'h0, 5, 0, mk_d(ACCESS_ACK_DATA, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0));
    chk("rd_hi_rdata", 256'(last_rdata), 256'(32'hAAAA_BBBB));

    // reset in the middle of an access
    @(posedge clk_i); #1; req_i = 1; we_i = 0; addr_i = 64'h4000_0000; TL_A_ready_i = 0;
    @(negedge clk_i);
    @(posedge clk_i); #1; req_i = 0;
    @(negedge clk_i);
    @(posedge clk_i); #1; rst_i = 1;
    @(posedge clk_i); #1; rst_i = 0;
    @(negedge clk_i);
    chk("midrst_a_valid", 256'(TL_A_valid_o), 256'(0));
    chk("midrst_rdata", 256'(rdata_o), 256'(0));
    chk("midrst_rvalid", 256'(rvalid_o), 256'(0));

    // misaligned read: no TL traffic
    f0 = fire_cnt;
    access(1'b0, 64'h2, 32'h0, 0, 0, '0);
    chk("mis_latency", 256'(r_cyc - g_cyc), 256'(1));
    chk("mis_err", 256'(last_err), 256'(1));
    chk("mis_rdata", 256'(last_rdata), 256'(0));
    chk("mis_no_a", 256'(fire_cnt), 256'(f0));

    // denied, then read answered with AccessAck
    access(1'b0, 64'h1000_0008, 32'h0, 0, 1, mk_d(ACCESS_ACK_DATA, 64'h1111_2222_3333_4444, 1'b1));
    chk("denied_err", 256'(last_err), 256'(1));
    chk("denied_rdata", 256'(last_rdata), 256'(0));
    access(1'b0, 64'h1000_000C, 32'h0, 0, 0, mk_d(ACCESS_ACK, 64'h1111_2222_3333_4444, 1'b0));
    chk("opc_err", 256'(last_err), 256'(1));
    chk("opc_rdata", 256'(last_rdata), 256'(0));

    // D beat while idle is not accepted and produces nothing
    r0 = rv_cnt;
    @(posedge clk_i); #1; TL_D_valid_i = 1; TL_D_bits_i = mk_d(ACCESS_ACK_DATA, 64'h5, 1'b0);
    repeat (3) @(posedge clk_i);
    #1; TL_D_valid_i = 0;
    @(negedge clk_i);
    chk("idle_d_ignored", 256'(rv_cnt), 256'(r0));

    if (TO_EN) begin
      access(1'b0, 64'h3000_0000, 32'h0, 0, -1, '0);
      chk("to_err", 256'(last_err), 256'(1));
      chk("to_rdata", 256'(last_rdata), 256'(0));
      chk("to_latency", 256'(r_cyc - g_cyc), 256'(1 + TO + 1));
      @(posedge clk_i); #1; req_i = 1; we_i = 0; addr_i = 64'h3000_0008;
      repeat (3) @(negedge clk_i);
      chk("to_gnt_held", 256'(gnt_o), 256'(0));
      @(posedge clk_i); #1; TL_D_valid_i = 1; TL_D_bits_i = mk_d(ACCESS_ACK_DATA, 64'h77, 1'b0);
      @(negedge clk_i);
      chk("to_late_d_ready", 256'(TL_D_ready_o), 256'(1));
      @(posedge clk_i); #1; TL_D_valid_i = 0; req_i = 0;
      access(1'b0, 64'h3000_0004, 32'h0, 0, 0, mk_d(ACCESS_ACK_DATA, 64'h9999_8888_0000_0001, 1'b0));
      chk("to_next_rdata", 256'(last_rdata), 256'(32'h9999_8888));
    end

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      logic        we;
      logic [63:0] a;
      we = 1'($urandom);
      a  = {$urandom, $urandom};
      a[1:0] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      d = '0;
      d.opcode  = ($urandom_range(0, 9) == 0) ? 3'($urandom) : (we ? ACCESS_ACK : ACCESS_ACK_DATA);
      d.denied  = ($urandom_range(0, 9) == 0);
      d.corrupt = ($urandom_range(0, 9) == 0);
      d.source  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      d.data    = {$urandom, $urandom};
      access(we, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), d);
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
    end

    repeat (3) @(negedge clk_i);
    chk("resp_drained", 256'(exp_rd_q.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg2tl_bridge.md
Name: reg2tl_bridge

Overview:
- Register-bus slave to TileLink-UL client bridge.
- Accepts 32-bit single-word register accesses from a simple initiator (debug module, boot ROM loader, config DMA) and issues one TileLink Get or PutFullData per access on a 64-bit A channel.
- Waits for the D response and returns read data and error status to the initiator.
- Strictly one transaction outstanding. Mirrors the TileLink-to-register path on the other end of the same fabric.

Parameters:
- ADDR_WIDTH, 64: register/TL address width.
- SOURCE_ID, 0: tl_pkg::source_t value driven on A.source; D.source is checked against it.
- TIMEOUT_CYCLES, 1024: WAIT_D cycle limit; used only with REG2TL_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- req_i  in  1  register request valid
- gnt_o  out  1  request accepted this cycle
- we_i  in  1  1 = write, 0 = read
- addr_i  in  ADDR_WIDTH  byte address
- wdata_i  in  32  write data
- rvalid_o  out  1  one-cycle response pulse, for reads and writes
- rdata_o  out  32  read data, valid with rvalid_o
- err_o  out  1  error flag, valid with rvalid_o
- TL_A_valid_o  out  1  A channel valid
- TL_A_ready_i  in  1  A channel ready
- TL_A_bits_o  out  tl_pkg::A_chan_bits_t  A channel payload
- TL_D_valid_i  in  1  D channel valid
- TL_D_ready_o  out  1  D channel ready
- TL_D_bits_i  in  tl_pkg::D_chan_bits_t  D channel payload

Behaviour:
- Clock is clk_i. Reset is rst_i, synchronous and active-high.
- Reset values: state IDLE. gnt_o, rvalid_o, err_o, TL_A_valid_o, TL_D_ready_o = 0. rdata_o = 0. All captured request registers = 0.
- FSM states: IDLE, SEND_A, WAIT_D, RESP.
- IDLE:
  - gnt_o = req_i, combinational.
  - On req_i, capture we_i, addr_i and wdata_i.
  - If addr_i[1:0] != 0: go to RESP with err = 1, rdata = 0. No TL traffic is issued.
  - Otherwise go to SEND_A.
- SEND_A:
  - TL_A_valid_o = 1; bits are driven from registers only and held stable until TL_A_ready_i.
  - opcode = PutFullData if we else Get.
  - size = 2 (4 bytes).
  - address = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - mask = 8'h0F if addr[2] == 0, else 8'hF0.
  - data = {wdata, wdata}, duplicated on both lanes.
  - param = 0, corrupt = 0, source = SOURCE_ID.
  - On TL_A_ready_i, go to WAIT_D.
- WAIT_D:
  - TL_D_ready_o = 1.
  - On TL_D_valid_i, capture rdata = addr[2] ? data[63:32] : data[31:0], then go to RESP.
  - err = denied | corrupt | source mismatch | opcode mismatch. Expected opcode is AccessAck for writes and AccessAckData for reads.
  - rdata is forced to 0 for writes and on error.
- RESP: rvalid_o = 1 for exactly one cycle; rdata_o and err_o are registered. Next state IDLE.
- gnt_o is 0 in every state except IDLE, so requests are held off until the current access completes.
- Latency: with A ready and D returned one cycle after A fire, gnt at cycle 0, A fire at 1, D at 2, rvalid at 3. Minimum request-to-request spacing is 4 cycles.
- D beats seen outside WAIT_D are ignored. TL_D_ready_o = 0 outside WAIT_D.
- Reset mid-operation returns to IDLE immediately and drops the in-flight access. Both TileLink ends share rst_i, so no stale response survives reset.

Optional Feature:
- Macro: REG2TL_TIMEOUT_EN.
- With the macro:
  - A counter runs in WAIT_D. When it reaches TIMEOUT_CYCLES-1 with no D beat, the bridge goes to RESP with err = 1, rdata = 0, and sets a stale flag.
  - While stale is set: TL_D_ready_o = 1 in IDLE, one D beat is dropped and stale clears, and gnt_o is forced to 0.
  - Counter and flag reset to 0.
- Without the macro: WAIT_D waits indefinitely. No counter or flag logic exists.

Decomposition:
- tl_pkg (existing): A_chan_bits_t, D_chan_bits_t, source_t, opcodes.
- sy_pkg: new constants REG2TL_SIZE_WORD = 2, REG2TL_MASK_LO = 8'h0F, REG2TL_MASK_HI = 8'hF0.
- FSM enum stays local to the module.
- No sub-module. Lane steering and mask generation are a few lines, kept inline.

Test Plan:
- Write 0x12345678 @ 0x1000_0004, A ready and D one cycle later:
  - A: PutFullData, address 0x1000_0004, mask 0xF0, data 0x12345678_12345678.
  - rvalid at cycle 3, err 0.
- Read @ 0x1000_0000, D data 0xAAAA_BBBB_CCCC_DDDD: A Get with mask 0x0F; rdata_o 0xCCCCDDDD, err 0.
- Read @ 0x1000_0004 with A_ready held low 5 cycles: A bits stable throughout, gnt_o 0 during stall, rdata_o 0xAAAABBBB.
- Read @ 0x2 (misaligned): no TL_A_valid_o, rvalid_o after 1 cycle with err 1, rdata 0.
- D with denied = 1, then a read answered with AccessAck: err_o 1 both times, rdata 0.
- REG2TL_TIMEOUT_EN, TIMEOUT_CYCLES = 8, no D:
  - err response after 8 WAIT_D cycles.
  - Late D beat is dropped, then the next request is granted.
